// File: rtl/uart_defs_pkg.sv
// uart_defs: shared packer state type and lane-count helpers
package uart_defs;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} PackState_t;
    function automatic int byte_lanes(input int w);
        return w / 8;
    endfunction
    function automatic int half_lanes(input int w);
        return w / 16;
    endfunction
endpackage

// File: rtl/uart_rx_pack_tmo.sv
// uart_rx_pack_tmo: saturating idle counter that requests a partial-word flush
module uart_rx_pack_tmo #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic             busy_i,
    input  logic             pop_i,
    input  logic             clr_i,
    output logic             hit_o
);
    logic [TMO_W-1:0] cnt;
    logic             armed;
    assign armed = en_i & busy_i & (timeout_i != '0);
    assign hit_o = armed & (cnt == timeout_i);
    // Holding at the compare value keeps the request pending while the output is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr_i | pop_i) cnt <= '0;
        else if (armed & ~hit_o & ~&cnt) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer: packs RX FIFO frames little-endian into words with idle-timeout flush
module uart_rx_packer #(
    parameter int WORD_W = 32,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              nine_bit_i,
    input  logic [TMO_W-1:0]  timeout_i,
    input  logic              flush_i,
    input  logic [8:0]        rx_d_i,
    input  logic              rx_d_valid_i,
    output logic              rx_d_ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic [2:0]        word_lanes_o,
    output logic              word_tmo_o,
    output logic              word_valid_o,
    input  logic              word_ready_i
);
    import uart_defs::*;
    localparam logic [2:0] BYTE_LANES = 3'(byte_lanes(WORD_W));
    localparam logic [2:0] HALF_LANES = 3'(half_lanes(WORD_W));
    localparam int OW = $clog2(WORD_W);
    PackState_t        state, state_nxt;
    logic [2:0]        cnt, cnt_nxt, lmax, idx;
    logic [OW-1:0]     off;
    logic [WORD_W-1:0] acc, acc_nxt;
    logic              run, full, can_move, tmo_hit, move, pop;
    assign lmax         = nine_bit_i ? HALF_LANES : BYTE_LANES;
    assign full         = state == FULL;
    assign can_move     = ~word_valid_o | word_ready_i;
    assign move         = ~flush_i & (full | tmo_hit) & can_move;
    // run keeps the pop request low while reset is held
    assign rx_d_ready_o = run & en_i & ~flush_i & (~full | can_move);
    assign pop          = rx_d_valid_i & rx_d_ready_o;
    assign idx          = move ? 3'd0 : cnt;
    assign off          = nine_bit_i ? OW'({idx, 4'b0}) : OW'({idx, 3'b0});
    uart_rx_pack_tmo #(.TMO_W(TMO_W)) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .timeout_i (timeout_i),
        .busy_i    (state != EMPTY),
        .pop_i     (pop),
        .clr_i     (flush_i | move),
        .hit_o     (tmo_hit)
    );
    always_comb begin
        acc_nxt = (move | flush_i) ? '0 : acc;
        cnt_nxt = (move | flush_i) ? 3'd0 : cnt;
        if (pop) begin
            if (nine_bit_i) acc_nxt[off +: 16] = {7'b0, rx_d_i};
            else acc_nxt[off +: 8] = rx_d_i[7:0];
            cnt_nxt = cnt_nxt + 3'd1;
        end
        state_nxt = (flush_i || cnt_nxt == 3'd0) ? EMPTY : (cnt_nxt == lmax) ? FULL : PARTIAL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run          <= 1'b0;
            state        <= EMPTY;
            cnt          <= '0;
            acc          <= '0;
            word_o       <= '0;
            word_lanes_o <= '0;
            word_tmo_o   <= 1'b0;
            word_valid_o <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            if (flush_i) word_valid_o <= 1'b0;
            else if (move) begin
                word_o       <= acc;
                word_lanes_o <= cnt;
                word_tmo_o   <= ~full;
                word_valid_o <= 1'b1;
            end else if (word_ready_i) word_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer: scoreboard bench for the word packer
module tb_uart_rx_packer;
    logic        clk = 0, rst_n = 0, en_i = 1, nine_bit_i = 0, flush_i = 0;
    logic [15:0] timeout_i = 0;
    logic [8:0]  rx_d_i = 0;
    logic        rx_d_valid_i = 0, rx_d_ready_o;
    logic [31:0] word_o;
    logic [2:0]  word_lanes_o;
    logic        word_tmo_o, word_valid_o, word_ready_i = 1;
    typedef struct { logic [31:0] w; logic [2:0] l; logic t; } exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0, stalls = 0;
    uart_rx_packer dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .nine_bit_i(nine_bit_i),
        .timeout_i(timeout_i), .flush_i(flush_i), .rx_d_i(rx_d_i),
        .rx_d_valid_i(rx_d_valid_i), .rx_d_ready_o(rx_d_ready_o),
        .word_o(word_o), .word_lanes_o(word_lanes_o), .word_tmo_o(word_tmo_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic expect_word(input logic [31:0] w, input logic [2:0] l, input logic t);
        exp_t e;
        e.w = w; e.l = l; e.t = t;
        exp_q.push_back(e);
    endtask
    // one frame per call; returns just after the clock edge that popped it
    task automatic send(input logic [8:0] d);
        int n = 0;
        rx_d_i = d;
        rx_d_valid_i = 1;
        @(negedge clk);
        while (!rx_d_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 0, 1);
        stalls += n;
        @(posedge clk);
        #1 rx_d_valid_i = 0;
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask
    always @(negedge clk) begin
        if (rst_n && word_valid_o && word_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_word", word_o, 0);
            else begin
                exp_exp_check(exp_q.pop_front());
            end
        end
    end
    task automatic exp_exp_check(input exp_t e);
        chk("word", word_o, e.w);
        chk("lanes", word_lanes_o, e.l);
        chk("tmo", word_tmo_o, e.t);
    endtask
    initial begin
        int n;
        #12;
        chk("rst_valid", word_valid_o, 0);
        chk("rst_word", word_o, 0);
        chk("rst_lanes", word_lanes_o, 0);
        chk("rst_tmo", word_tmo_o, 0);
        chk("rst_ready", rx_d_ready_o, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        // byte mode, back-to-back, completing frame visible one cycle later
        expect_word(32'h44332211, 4, 0);
        stalls = 0;
        send(9'h011); send(9'h022); send(9'h033); send(9'h044);
        chk("t1_stalls", stalls, 0);
        @(negedge clk) chk("t1_lat0", word_valid_o, 0);
        @(negedge clk) chk("t1_lat1", word_valid_o, 1);
        drain();
        // 9-bit mode, full word then timeout-flushed single lane
        @(posedge clk); #1 nine_bit_i = 1;
        expect_word(32'h00CD01AB, 2, 0);
        send(9'h1AB); send(9'h0CD);
        drain();
        @(posedge clk); #1 timeout_i = 5;
        expect_word(32'h01020101, 2, 0);
        expect_word(32'h000001EF, 1, 1);
        send(9'h101); send(9'h102); send(9'h1EF);
        n = 0;
        @(negedge clk);
        while (!(word_valid_o && word_tmo_o) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t2_tmo_latency", n, 6);
        drain();
        // backpressure: 12 bytes, output held, accumulator fills
        @(posedge clk); #1 timeout_i = 0; nine_bit_i = 0; word_ready_i = 0;
        expect_word(32'h04030201, 4, 0);
        expect_word(32'h08070605, 4, 0);
        expect_word(32'h0C0B0A09, 4, 0);
        stalls = 0;
        for (int i = 1; i <= 8; i++) send(9'(i));
        chk("t3_stalls", stalls, 0);
        rx_d_i = 9'h009; rx_d_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_ready_low", rx_d_ready_o, 0);
            chk("t3_hold_valid", word_valid_o, 1);
            chk("t3_hold_word", word_o, 32'h04030201);
        end
        @(posedge clk); #1 word_ready_i = 1; rx_d_valid_i = 0;
        for (int i = 9; i <= 12; i++) send(9'(i));
        drain();
        // timeout collides with a pop: timeout wins, new byte goes to lane 0
        @(posedge clk); #1 timeout_i = 3;
        expect_word(32'h0000A2A1, 2, 1);
        expect_word(32'hA6A5A4A3, 4, 0);
        send(9'h0A1); send(9'h0A2);
        repeat (3) @(posedge clk);
        #1;
        send(9'h0A3); send(9'h0A4); send(9'h0A5); send(9'h0A6);
        drain();
        // flush while output is held and three bytes are buffered
        @(posedge clk); #1 timeout_i = 0; word_ready_i = 0;
        send(9'h0B1); send(9'h0B2); send(9'h0B3); send(9'h0B4);
        send(9'h0C1); send(9'h0C2); send(9'h0C3);
        @(negedge clk) chk("t5_valid_before", word_valid_o, 1);
        @(posedge clk); #1 flush_i = 1; rx_d_i = 9'h055; rx_d_valid_i = 1;
        @(negedge clk) chk("t5_ready_in_flush", rx_d_ready_o, 0);
        @(posedge clk); #1 flush_i = 0; rx_d_valid_i = 0;
        @(negedge clk) chk("t5_valid_after", word_valid_o, 0);
        @(posedge clk); #1 word_ready_i = 1;
        expect_word(32'hD4D3D2D1, 4, 0);
        send(9'h0D1); send(9'h0D2); send(9'h0D3); send(9'h0D4);
        drain();
        // asynchronous reset mid-word
        send(9'h0E1); send(9'h0E2);
        @(posedge clk); #3 rst_n = 0;
        #1;
        chk("t6_valid", word_valid_o, 0);
        chk("t6_word", word_o, 0);
        chk("t6_lanes", word_lanes_o, 0);
        chk("t6_tmo", word_tmo_o, 0);
        chk("t6_ready", rx_d_ready_o, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        expect_word(32'hF4F3F2F1, 4, 0);
        send(9'h0F1); send(9'h0F2); send(9'h0F3); send(9'h0F4);
        drain();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_packer.md
Name: uart_rx_packer

Overview:
- Sits directly downstream of the UART receiver's RX FIFO, in the system clock domain.
- Pops received frames (9-bit entries) and packs them little-endian into 32-bit words for a bus-side consumer (DMA or register read port).
- Partial words are flushed on a programmable idle timeout, so a short message is never stuck waiting for more bytes.

Parameters:
- WORD_W, 32, output word width; must be a multiple of 16.
- TMO_W, 16, width of the idle-timeout counter and configuration value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en_i  in  1  packer enable; when low, no pops and the timeout counter is held
- nine_bit_i  in  1  1: each frame occupies a 16-bit lane holding {7'b0, frame[8:0]}; 0: each frame occupies an 8-bit lane holding frame[7:0]
- timeout_i  in  TMO_W  idle cycles before a partial word is flushed; 0 disables the timeout
- flush_i  in  1  synchronous discard of the partial word and the output register
- rx_d_i  in  9  frame from the RX FIFO
- rx_d_valid_i  in  1  frame valid
- rx_d_ready_o  out  1  pop request to the RX FIFO
- word_o  out  WORD_W  packed word; unused upper lanes are zero
- word_lanes_o  out  3  number of valid lanes in word_o (1..WORD_W/8 in byte mode, 1..WORD_W/16 in 9-bit mode)
- word_tmo_o  out  1  word was emitted by timeout, not because it filled
- word_valid_o  out  1  output valid
- word_ready_i  in  1  output accept

Behaviour:
- Reset: all outputs 0, accumulator empty, lane count 0, timeout counter 0.
- Internal: accumulator register, lane counter, single-entry output register, timeout counter.
- Input acceptance: rx_d_ready_o = en_i & ~flush_i & (accumulator not full, or the full accumulator can move to the output this cycle).
- The output can accept a move when word_valid_o is 0, or when word_valid_o is 1 and word_ready_i is 1 (accept and reload in the same cycle, no bubble).
- Pop occurs when rx_d_valid_i & rx_d_ready_o; the frame is written into lane [lane count], and the lane count increments.
- Full condition: lane count reaches the lane maximum (4 in byte mode, 2 in 9-bit mode at WORD_W=32).
- When full, the accumulator moves to the output register on the next cycle the output can accept a move:
  - word_lanes_o = maximum, word_tmo_o = 0.
  - Lane count clears in the same cycle; a pop in that same cycle lands in lane 0.
  - Steady-state throughput is one frame per clock.
- Latency: the frame that completes a word is visible on word_o one cycle after its pop, if the output register is free.
- Timeout counter:
  - Clears on every pop.
  - Increments each cycle while en_i=1, timeout_i≠0, lane count > 0 and no pop occurs.
  - Saturates at all-ones.
- When counter == timeout_i, a partial move is requested:
  - It moves on the first cycle the output can accept a move; word_lanes_o = lane count, word_tmo_o = 1.
  - Unused lanes are zero, and the counter clears.
  - A pop arriving in the same cycle as the partial move goes to lane 0 of the new word (the timeout wins).
- Output register holds word_o, word_lanes_o and word_tmo_o stable while word_valid_o=1 and word_ready_i=0 (AXI-style valid/ready).
- flush_i (one cycle):
  - Clears the accumulator, lane count, counter and word_valid_o.
  - Forces rx_d_ready_o=0, so no pop happens that cycle.
  - Flush has priority over every other event.
- nine_bit_i or WORD_W lane sizing changing mid-word is undefined; software flushes before changing it.
- en_i falling mid-word: the partial word is retained and the counter is frozen; resuming continues packing.
- Reset mid-operation: all state is discarded asynchronously, with no output glitch beyond the return to reset values.
- FSM (encodes accumulator state; the output register is tracked by the word_valid_o flag):
  - EMPTY: go to PARTIAL on a pop.
  - PARTIAL:
    - go to FULL when the pop fills the last lane and the move is blocked;
    - go back to EMPTY on a move with no pop;
    - stay in PARTIAL on a move with a pop, or on a normal pop.
  - FULL: go to EMPTY on a move, or to PARTIAL on a move plus pop.
  - Any state goes to EMPTY on flush_i.

Decomposition:
- uart_defs package: PackState_t (EMPTY, PARTIAL, FULL); lane-max constants BYTE_LANES = WORD_W/8 and HALF_LANES = WORD_W/16 as localparam functions.
- One natural sub-module: uart_rx_pack_tmo, containing the saturating idle counter, the compare and the enable gating (about 40 lines).
- Lane insert and output register stay in the top module.

Test Plan:
- Byte mode, timeout 0: push 0x11, 0x22, 0x33, 0x44 back-to-back with word_ready_i=1 → one word 0x44332211, lanes=4, tmo=0, one cycle after the 4th pop; rx_d_ready_o stays 1 throughout.
- 9-bit mode: push 0x1AB, 0x0CD → word 0x00CD01AB, lanes=2; then push 3 frames with timeout_i=5 → second word after the third frame's pop, then 0x000001xx with lanes=1, tmo=1 exactly 5 idle cycles after the last pop.
- Backpressure: word_ready_i=0, stream 12 bytes → first word held stable, accumulator fills, rx_d_ready_o drops after byte 8; releasing word_ready_i → words drained in order with no loss or duplication.
- Timeout/pop collision: 2 bytes buffered, timeout_i=3, a new byte arrives exactly when the counter hits 3 → emitted word has lanes=2, and the new byte sits in lane 0 of the next word.
- Flush during backpressure: output valid and 3 bytes in the accumulator, assert flush_i → word_valid_o=0 next cycle, rx_d_ready_o=0 during the flush cycle, next 4 bytes form a clean word.
- Async reset asserted mid-word → all outputs 0 immediately; after release, a fresh 4-byte stream packs correctly.
